// File: rtl/twos_complement_serial.sv
// Serial two's-complement unit: PASS/NEG/ABS/NABS of a WIDTH-bit operand,
// DIGIT bits per cycle, LSB first, with valid/ready handshakes on both sides.
module twos_complement_serial #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf,
   output logic             busy
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [1:0] M_PASS = 2'b00;
   localparam logic [1:0] M_NEG  = 2'b01;
   localparam logic [1:0] M_ABS  = 2'b10;
   localparam logic [1:0] M_NABS = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t          r_state, w_next;
   logic [WIDTH-1:0] r_opnd;
   logic [WIDTH-1:0] r_res;
   logic [CW-1:0]    r_cnt;
   logic             r_inv;
   logic             r_carry;
   logic             r_valid;
   logic             r_ovf;

   logic             w_accept;
   logic             w_last;
   logic             w_inv;
   logic [DIGIT-1:0] w_digit;
   logic [DIGIT-1:0] w_sum;
   logic             w_cout;

   assign w_accept = in_valid && (r_state == S_IDLE);
   assign w_last   = (r_cnt == CW'(NDIG - 1));
   assign w_inv    = (in_mode == M_NEG)
                   | ((in_mode == M_ABS)  &  in_data[WIDTH-1])
                   | ((in_mode == M_NABS) & ~in_data[WIDTH-1]);

   // One digit of (operand ^ inv) + carry per BUSY cycle
   assign w_digit = r_opnd[r_cnt*DIGIT +: DIGIT];
   assign {w_cout, w_sum} = {1'b0, w_digit ^ {DIGIT{r_inv}}} + {{DIGIT{1'b0}}, r_carry};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)  w_next = S_BUSY;
         S_BUSY:  if (w_last)    w_next = S_DONE;
         S_DONE:  if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opnd  <= '0;
         r_res   <= '0;
         r_cnt   <= '0;
         r_inv   <= 1'b0;
         r_carry <= 1'b0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         r_opnd  <= in_data;
         r_inv   <= w_inv;
         r_carry <= w_inv;
         r_cnt   <= '0;
      end else if (r_state == S_BUSY) begin
         r_res[r_cnt*DIGIT +: DIGIT] <= w_sum;
         r_carry <= w_cout;
         r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
         if (w_last) begin
            r_valid <= 1'b1;
            // Only an inverted most-negative operand wraps back onto itself
            r_ovf   <= r_inv & (r_opnd == MIN_VAL);
         end
      end else if ((r_state == S_DONE) && out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign out_valid = r_valid;
   assign out_data  = r_res;
   assign out_ovf   = r_ovf;

endmodule
